reg_wr_arbiter: RTL and testbench
=================================

# reg_wr_arbiter

Write-port arbiter for a shared 32-bit enable register (clk/rst/CE/D/Q register used in the datapath). Up to NREQ requesters compete for the register's single write port. The block grants one requester per cycle using round-robin priority with a bounded burst. It drives the register's CE and D from registered outputs, so the register sees a clean one-write-per-cycle stream.

## Interface
Parameters:
- WIDTH, 32, data width of the shared register
- NREQ, 4, number of requesters (2..8)
- MAX_BURST, 4, max consecutive transfers one owner keeps while others wait (>=1)

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  NREQ  req[i] high = requester i presents valid wdata word i
- wdata  in  NREQ*WIDTH  packed data; word i = wdata[i*WIDTH +: WIDTH]
- ack  out  NREQ  one-hot, combinational; transfer for i occurs at rising edge where req[i] && ack[i]
- reg_ce  out  1  registered write enable to the shared register
- reg_d  out  WIDTH  registered write data to the shared register
- grant_id  out  clog2(NREQ)  registered index of requester whose word is on reg_d
- busy  out  1  registered; high while an owner holds the port (owner_vld)

## Operation
- Internal state: owner (index), owner_vld, burst_cnt (0..MAX_BURST), last (index of most recent owner).
- Selection (combinational, each cycle):
  - Owner continues: sel = owner if owner_vld && req[owner] && (burst_cnt < MAX_BURST || no other req bit set).
  - Otherwise: sel = first i with req[i] set, scanning last+1, last+2, … modulo NREQ.
  - The scan includes last itself, as the final candidate.
- ack = onehot(sel) when any req is set and rst is high; ack = 0 when no req is set or rst is low.
- Requester protocol:
  - Hold req and wdata stable until the edge where ack is seen high.
  - After that edge, either drop req or present the next word.
  - ack may change only in response to req changes or clock edges; requesters must not make req depend combinationally on ack.
- On a rising edge with a transfer to sel:
  - reg_ce <= 1, reg_d <= wdata[sel], grant_id <= sel.
  - owner <= sel, owner_vld <= 1, last <= sel.
  - burst_cnt <= 1 when sel != owner, or when owner_vld was 0.
  - burst_cnt <= 1 when sel == owner, burst_cnt == MAX_BURST and no other req is set (fresh burst).
  - Otherwise burst_cnt <= burst_cnt + 1.
- On a rising edge with no transfer:
  - reg_ce <= 0; reg_d and grant_id hold.
  - owner_vld <= 0, burst_cnt <= 0; last holds.
- busy = owner_vld.
- The arbiter never writes without a transfer, and never issues two writes in one cycle.

## Timing
- Reset (rst low, asynchronous) forces:
  - reg_ce=0, reg_d=0, grant_id=0, busy=0.
  - owner_vld=0, burst_cnt=0, owner=0, last=NREQ-1, so the first scan starts at requester 0.
  - ack forced 0 while rst is low.
- Reset deasserted mid-burst: no write completes at any edge where rst is low. The first grant after release starts from requester 0.
- Latency: a transfer at edge t produces reg_ce=1 and reg_d=word during cycle t..t+1. The shared register captures it at edge t+1.
- Throughput: one word per cycle, sustained, for any mix of requesters.
- Single requester with req held continuously gets a transfer every cycle indefinitely; bursts renew at MAX_BURST.
- Fairness: with all NREQ requesting continuously, each requester waits at most (NREQ-1)*MAX_BURST cycles between grant windows.
- If the owner drops req while others request, the grant moves to the next round-robin requester in the same cycle, with no bubble.
- If req[i] rises in the same cycle the owner hits MAX_BURST, i is considered for that cycle's selection.

## Test plan
- **Reset:** hold rst=0 with req=4'b1111.
  - Expect ack=0, reg_ce=0, reg_d=0, busy=0.
  - Release rst; the first edge grants requester 0.
- **Single requester:** req=4'b0100, wdata word2=32'hFFFFFFFF, held 6 cycles.
  - ack=4'b0100 every cycle.
  - reg_ce=1 with reg_d=32'hFFFFFFFF and grant_id=2 from the cycle after the first edge.
  - No gap after the 4th transfer.
- **Burst limit:** req=4'b0011 held; word0=32'h0000_0001, word1=32'h0000_0002.
  - Grant sequence 0,0,0,0,1,1,1,1,0…
  - reg_d matches one cycle later.
- **Owner drop:** req=4'b1001, owner 0 drops req after 2 transfers.
  - Requester 3 is acked the next cycle, with no reg_ce=0 bubble.
  - Then req=0 → reg_ce=0 and busy=0 one cycle later.
- **Round-robin wrap:** last=3, req=4'b1101 held with MAX_BURST=1.
  - Grants 0,2,3,0,2,3…
  - grant_id and reg_d track each grant.
- **Async reset mid-burst:** assert rst=0 between edges while busy=1.
  - reg_ce and busy drop immediately, without waiting for a clock edge.
  - After release, arbitration restarts at requester 0.

Source files
------------

// File: rtl/reg_wr_arbiter.sv
// Round-robin write-port arbiter with bounded bursts for a shared CE/D register.
// One requester is acked per cycle; the winning word is registered onto reg_d/reg_ce.
module reg_wr_arbiter #(
    parameter int WIDTH     = 32,
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4,
    localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1,
    localparam int CW       = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       ack,
    output logic                  reg_ce,
    output logic [WIDTH-1:0]      reg_d,
    output logic [IDW-1:0]        grant_id,
    output logic                  busy
);

    localparam logic [CW-1:0] MAXB = CW'(MAX_BURST);

    logic [IDW-1:0]   owner;
    logic [IDW-1:0]   last;
    logic [IDW-1:0]   sel;
    logic             owner_vld;
    logic [CW-1:0]    burst_cnt;
    logic             any_req;
    logic             others;
    logic             cont;
    logic             found;
    logic [IDW-1:0]   scan_idx;
    logic [WIDTH-1:0] wdata_sel;

    function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] idx);
        onehot = '0;
        onehot[idx] = 1'b1;
    endfunction

    // Owner keeps the port until its burst is spent and someone else is waiting;
    // otherwise scan from last+1, wrapping back to last as the final candidate.
    always_comb begin
        any_req  = |req;
        others   = |(req & ~onehot(owner));
        cont     = owner_vld && req[owner] && ((burst_cnt < MAXB) || !others);
        sel      = last;
        found    = 1'b0;
        scan_idx = '0;
        if (cont) begin
            sel = owner;
        end else begin
            for (int k = 1; k <= NREQ; k++) begin
                scan_idx = IDW'((int'(last) + k) % NREQ);
                if (!found && req[scan_idx]) begin
                    sel   = scan_idx;
                    found = 1'b1;
                end
            end
        end
        wdata_sel = wdata[int'(sel)*WIDTH +: WIDTH];
        ack       = '0;
        if (any_req && rst) begin
            ack = onehot(sel);
        end
    end

    // Any set req bit means the selected requester transfers at this edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reg_ce    <= 1'b0;
            reg_d     <= '0;
            grant_id  <= '0;
            owner     <= '0;
            owner_vld <= 1'b0;
            burst_cnt <= '0;
            last      <= IDW'(NREQ - 1);
        end else if (any_req) begin
            reg_ce    <= 1'b1;
            reg_d     <= wdata_sel;
            grant_id  <= sel;
            owner     <= sel;
            owner_vld <= 1'b1;
            last      <= sel;
            if (!owner_vld || (sel != owner)) begin
                burst_cnt <= CW'(1);
            end else if ((burst_cnt == MAXB) && !others) begin
                burst_cnt <= CW'(1);
            end else begin
                burst_cnt <= burst_cnt + CW'(1);
            end
        end else begin
            reg_ce    <= 1'b0;
            owner_vld <= 1'b0;
            burst_cnt <= '0;
        end
    end

    assign busy = owner_vld;

endmodule

// File: tb/tb_reg_wr_arbiter.sv
// Directed bench for reg_wr_arbiter: reset, single requester, burst limit,
// owner drop, round-robin wrap (MAX_BURST=1 instance) and async reset mid-burst.
module tb_reg_wr_arbiter;

    logic         clk;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] wdata;
    logic [3:0]   ack;
    logic         reg_ce;
    logic [31:0]  reg_d;
    logic [1:0]   grant_id;
    logic         busy;

    logic         rst2;
    logic [3:0]   req2;
    logic [127:0] wdata2;
    logic [3:0]   ack2;
    logic         reg_ce2;
    logic [31:0]  reg_d2;
    logic [1:0]   grant_id2;
    logic         busy2;

    int n_tests;
    int n_fail;

    reg_wr_arbiter #(.WIDTH(32), .NREQ(4), .MAX_BURST(4)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .ack(ack),
        .reg_ce(reg_ce), .reg_d(reg_d), .grant_id(grant_id), .busy(busy)
    );

    reg_wr_arbiter #(.WIDTH(32), .NREQ(4), .MAX_BURST(1)) dut_rr (
        .clk(clk), .rst(rst2), .req(req2), .wdata(wdata2), .ack(ack2),
        .reg_ce(reg_ce2), .reg_d(reg_d2), .grant_id(grant_id2), .busy(busy2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b0;
        req   = 4'b1111;
        wdata = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
        tick();
        tick();
        n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL reset_ack got=%b exp=%b", ack, 4'b0000); end
        n_tests++; if (reg_ce !== 1'b0) begin n_fail++; $display("FAIL reset_ce got=%b exp=0", reg_ce); end
        n_tests++; if (reg_d !== 32'h0) begin n_fail++; $display("FAIL reset_d got=%h exp=0", reg_d); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_gid got=%0d exp=0", grant_id); end
        rst = 1'b1;
        #1;
        n_tests++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL reset_first_ack got=%b exp=0001", ack); end
        tick();
        n_tests++; if (reg_ce !== 1'b1) begin n_fail++; $display("FAIL reset_first_ce got=%b exp=1", reg_ce); end
        n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_first_gid got=%0d exp=0", grant_id); end
        n_tests++; if (reg_d !== 32'hA0) begin n_fail++; $display("FAIL reset_first_d got=%h exp=a0", reg_d); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_first_busy got=%b exp=1", busy); end
        req = 4'b0000;
        tick();
        n_tests++; if (reg_ce !== 1'b0) begin n_fail++; $display("FAIL reset_idle_ce got=%b exp=0", reg_ce); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        wdata[2*32 +: 32] = 32'hFFFF_FFFF;
        req = 4'b0100;
        #1;
        for (int k = 0; k < 6; k++) begin
            n_tests++; if (ack !== 4'b0100) begin n_fail++; $display("FAIL single_ack[%0d] got=%b exp=0100", k, ack); end
            tick();
            n_tests++; if (reg_ce !== 1'b1) begin n_fail++; $display("FAIL single_ce[%0d] got=%b exp=1", k, reg_ce); end
            n_tests++; if (reg_d !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL single_d[%0d] got=%h exp=ffffffff", k, reg_d); end
            n_tests++; if (grant_id !== 2'd2) begin n_fail++; $display("FAIL single_gid[%0d] got=%0d exp=2", k, grant_id); end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_burst_limit();
        int exp_g[9] = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
        logic [3:0] exp_ack;
        wdata[0*32 +: 32] = 32'h0000_0001;
        wdata[1*32 +: 32] = 32'h0000_0002;
        req = 4'b0011;
        #1;
        for (int k = 0; k < 9; k++) begin
            exp_ack = 4'b0001 << exp_g[k];
            n_tests++; if (ack !== exp_ack) begin n_fail++; $display("FAIL burst_ack[%0d] got=%b exp=%b", k, ack, exp_ack); end
            tick();
            n_tests++; if (grant_id !== 2'(exp_g[k])) begin n_fail++; $display("FAIL burst_gid[%0d] got=%0d exp=%0d", k, grant_id, exp_g[k]); end
            n_tests++; if (reg_d !== 32'(exp_g[k] + 1)) begin n_fail++; $display("FAIL burst_d[%0d] got=%h exp=%h", k, reg_d, exp_g[k] + 1); end
            n_tests++; if (reg_ce !== 1'b1) begin n_fail++; $display("FAIL burst_ce[%0d] got=%b exp=1", k, reg_ce); end
        end
        req = 4'b0000;
        tick();
    endtask

    task automatic test_owner_drop();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        wdata[0*32 +: 32] = 32'h1111_0000;
        wdata[3*32 +: 32] = 32'h3333_0003;
        req = 4'b1001;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_tests++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL drop_ack0[%0d] got=%b exp=0001", k, ack); end
            tick();
            n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL drop_gid0[%0d] got=%0d exp=0", k, grant_id); end
            n_tests++; if (reg_d !== 32'h1111_0000) begin n_fail++; $display("FAIL drop_d0[%0d] got=%h exp=11110000", k, reg_d); end
        end
        req = 4'b1000;
        #1;
        n_tests++; if (ack !== 4'b1000) begin n_fail++; $display("FAIL drop_ack3 got=%b exp=1000", ack); end
        tick();
        n_tests++; if (reg_ce !== 1'b1) begin n_fail++; $display("FAIL drop_nobubble_ce got=%b exp=1", reg_ce); end
        n_tests++; if (grant_id !== 2'd3) begin n_fail++; $display("FAIL drop_gid3 got=%0d exp=3", grant_id); end
        n_tests++; if (reg_d !== 32'h3333_0003) begin n_fail++; $display("FAIL drop_d3 got=%h exp=33330003", reg_d); end
        req = 4'b0000;
        #1;
        n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL drop_idle_ack got=%b exp=0000", ack); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drop_busy_held got=%b exp=1", busy); end
        tick();
        n_tests++; if (reg_ce !== 1'b0) begin n_fail++; $display("FAIL drop_idle_ce got=%b exp=0", reg_ce); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle_busy got=%b exp=0", busy); end
        n_tests++; if (reg_d !== 32'h3333_0003) begin n_fail++; $display("FAIL drop_d_hold got=%h exp=33330003", reg_d); end
    endtask

    task automatic test_rr_wrap();
        int exp_g[6] = '{0, 2, 3, 0, 2, 3};
        logic [3:0] exp_ack;
        wdata2 = {32'h0000_00C3, 32'h0000_00C2, 32'h0000_00C1, 32'h0000_00C0};
        req2 = 4'b1101;
        rst2 = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            exp_ack = 4'b0001 << exp_g[k];
            n_tests++; if (ack2 !== exp_ack) begin n_fail++; $display("FAIL rr_ack[%0d] got=%b exp=%b", k, ack2, exp_ack); end
            tick();
            n_tests++; if (grant_id2 !== 2'(exp_g[k])) begin n_fail++; $display("FAIL rr_gid[%0d] got=%0d exp=%0d", k, grant_id2, exp_g[k]); end
            n_tests++; if (reg_d2 !== 32'(32'hC0 + exp_g[k])) begin n_fail++; $display("FAIL rr_d[%0d] got=%h exp=%h", k, reg_d2, 32'hC0 + exp_g[k]); end
        end
        req2 = 4'b0000;
        tick();
    endtask

    task automatic test_async_reset();
        rst = 1'b0;
        #1;
        rst = 1'b1;
        wdata = {32'h0000_00A3, 32'h0000_00A2, 32'h0000_00A1, 32'h0000_00A0};
        req = 4'b1111;
        tick();
        tick();
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL async_pre_busy got=%b exp=1", busy); end
        n_tests++; if (reg_ce !== 1'b1) begin n_fail++; $display("FAIL async_pre_ce got=%b exp=1", reg_ce); end
        #2;
        rst = 1'b0;
        #1;
        n_tests++; if (reg_ce !== 1'b0) begin n_fail++; $display("FAIL async_ce got=%b exp=0", reg_ce); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL async_busy got=%b exp=0", busy); end
        n_tests++; if (ack !== 4'b0000) begin n_fail++; $display("FAIL async_ack got=%b exp=0000", ack); end
        n_tests++; if (reg_d !== 32'h0) begin n_fail++; $display("FAIL async_d got=%h exp=0", reg_d); end
        tick();
        n_tests++; if (reg_ce !== 1'b0) begin n_fail++; $display("FAIL async_held_ce got=%b exp=0", reg_ce); end
        #2;
        rst = 1'b1;
        #1;
        n_tests++; if (ack !== 4'b0001) begin n_fail++; $display("FAIL async_rel_ack got=%b exp=0001", ack); end
        tick();
        n_tests++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL async_rel_gid got=%0d exp=0", grant_id); end
        n_tests++; if (reg_d !== 32'hA0) begin n_fail++; $display("FAIL async_rel_d got=%h exp=a0", reg_d); end
        n_tests++; if (reg_ce !== 1'b1) begin n_fail++; $display("FAIL async_rel_ce got=%b exp=1", reg_ce); end
        req = 4'b0000;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst     = 1'b0;
        req     = 4'b0000;
        wdata   = '0;
        rst2    = 1'b0;
        req2    = 4'b0000;
        wdata2  = '0;
        test_reset();
        test_single();
        test_burst_limit();
        test_owner_drop();
        test_rr_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
